// File: rtl/ioctl_sdram_loader_pkg.sv
// ioctl_sdram_loader_pkg: shared state encoding, FIFO depth and widths for the ioctl SDRAM loader
package ioctl_sdram_loader_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int BE_W = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int ENTRY_W = ADDR_W + DATA_W + BE_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } entry_t;
endpackage

// File: rtl/ioctl_word_fifo.sv
// ioctl_word_fifo: two-entry write FIFO of {addr, data, be} words headed for SDRAM
module ioctl_word_fifo
  import ioctl_sdram_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count
);
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic wr_ptr, rd_ptr, do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CNT_W'(FIFO_DEPTH) || do_pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
endmodule

// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: packs ioctl download bytes into 16-bit SDRAM writes,
// throttling the byte stream through clkref_n so the 2-entry FIFO never overflows.
module ioctl_sdram_loader
  import ioctl_sdram_loader_pkg::*;
#(
  parameter logic [5:0]        INDEX = 6'd0,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 24'd0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              clkref_n,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [BE_W-1:0]   mem_be,
  output logic              busy,
  output logic              load_done,
  output logic [24:0]       load_bytes
);
  logic [1:0] state, nxt, gcnt;
  logic [ADDR_W-1:0] p_addr, word;
  logic [DATA_W-1:0] p_data, base_data, m_data;
  logic [BE_W-1:0] p_be, m_be;
  logic [CNT_W-1:0] count;
  logic acc, fresh, conflict, flush_push, old_word, push, grant, unused;
  entry_t push_e;
  assign unused = &{1'b0, ioctl_index[7:6]};
  assign acc = state == S_LOAD && ioctl_wr;
  assign word = ioctl_addr[24:1];
  assign fresh = p_be == '0 || p_addr != word;
  assign conflict = acc && p_be != '0 && p_addr != word;
  assign flush_push = state == S_FLUSH && p_be != '0 && count != CNT_W'(FIFO_DEPTH);
  assign old_word = conflict || flush_push;
  assign base_data = fresh ? '0 : p_data;
  assign m_data = ioctl_addr[0] ? {ioctl_dout, base_data[7:0]} : {base_data[15:8], ioctl_dout};
  assign m_be = (fresh ? 2'b00 : p_be) | (ioctl_addr[0] ? 2'b10 : 2'b01);
  assign push = old_word || (acc && m_be == 2'b11);
  assign mem_req = count != '0;
  assign busy = state != S_IDLE;
  assign load_done = state == S_DONE;
  // A new byte slot is offered only with an empty FIFO, so one accepted byte can never overflow it
  assign grant = state == S_LOAD && nxt == S_LOAD && count == '0 && gcnt == '0;
  always_comb
    case (state)
      S_IDLE:  nxt = (ioctl_download && ioctl_index[5:0] == INDEX) ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = ioctl_download ? S_LOAD : S_FLUSH;
      S_FLUSH: nxt = (p_be == '0 && count == '0) ? S_DONE : S_FLUSH;
      default: nxt = S_IDLE;
    endcase
  always_comb begin
    push_e.addr = BASE_ADDR + (old_word ? p_addr : word);
    push_e.data = old_word ? p_data : m_data;
    push_e.be = old_word ? p_be : m_be;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      clkref_n <= 1'b0;
      gcnt <= '0;
      load_bytes <= '0;
      p_addr <= '0;
      p_data <= '0;
      p_be <= '0;
    end else begin
      state <= nxt;
      clkref_n <= nxt == S_FLUSH || (nxt == S_LOAD && !grant);
      gcnt <= grant ? 2'd2 : (ioctl_wr || gcnt == '0) ? 2'd0 : gcnt - 2'd1;
      if (state == S_IDLE && nxt == S_LOAD) load_bytes <= '0;
      else if (acc) load_bytes <= load_bytes + 25'd1;
      if (acc) begin
        p_addr <= word;
        p_data <= m_be == 2'b11 ? '0 : m_data;
        p_be <= m_be == 2'b11 ? '0 : m_be;
      end else if (flush_push) begin
        p_data <= '0;
        p_be <= '0;
      end
    end
  ioctl_word_fifo u_fifo (
    .clk(clk_sys),
    .rst_n(reset_n),
    .push(push),
    .din(push_e),
    .pop(mem_ack && mem_req),
    .head({mem_addr, mem_din, mem_be}),
    .count(count)
  );
endmodule
